seq_div: RTL
============

Name: seq_div

Overview:
- Sequential restoring divider; the inverse of the ALU's 4x4 array multiplier.
- Takes a 2*WIDTH-bit dividend and a WIDTH-bit divisor. Produces a WIDTH-bit quotient, a WIDTH-bit remainder and an overflow flag.
- Resolves one quotient bit per clock and sits beside the multiplier in the ALU datapath.
- Uses a start/busy/done handshake so the ALU controller can issue divides and wait for completion.

Parameters:
- WIDTH, 4, divisor/quotient/remainder width; dividend is 2*WIDTH bits.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request a divide; sampled only in IDLE.
- dividend  input  2*WIDTH  numerator; captured on the accepting edge.
- divisor  input  WIDTH  denominator; captured on the accepting edge.
- busy  output  1  high from acceptance until done is asserted.
- done  output  1  one-cycle pulse; results valid.
- quotient  output  WIDTH  registered quotient; held until the next accepted start.
- remainder  output  WIDTH  registered remainder; held until the next accepted start.
- ovf  output  1  quotient does not fit in WIDTH bits (includes divisor == 0); held like the results.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (rst_n low, at any time, including mid-operation):
  - State goes to IDLE.
  - busy=0, done=0, quotient=0, remainder=0, ovf=0.
  - Internal remainder/shift/count registers are cleared.
  - Any operation in flight is discarded.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at a rising edge is accepted.
  - Latch divisor.
  - Partial remainder P (WIDTH+1 bits) = {0, dividend[2W-1:W]}.
  - Shift register S = dividend[W-1:0].
  - Iteration counter = WIDTH.
  - Compute ovf_int = (dividend[2W-1:W] >= divisor).
  - Go to RUN; busy=1 from the following cycle.
- RUN, one iteration per cycle:
  - Trial T = {P[W-1:0], S[W-1]} - {0, divisor}, computed in WIDTH+1 bits.
  - If T is non-negative: P = T, quotient bit = 1.
  - Otherwise: P = {P[W-1:0], S[W-1]}, quotient bit = 0.
  - S shifts left, with the quotient bit entering the LSB.
  - Counter decrements; on the last iteration, go to DONE.
- DONE (exactly one cycle):
  - done=1 and busy=0.
  - Normal case: quotient = S, remainder = P[W-1:0], ovf = 0.
  - If ovf_int: quotient = all ones, remainder = 0, ovf = 1.
  - Next state is IDLE.
- Outputs update on the edge entering DONE and are held through IDLE until the next accepted start.
- Latency: done is high in the cycle beginning WIDTH+1 edges after the accepting edge; for WIDTH=4, that is 5 edges.
- start while busy (RUN or DONE) is ignored and has no effect on the operation in flight.
- start held high continuously: a new divide is accepted on the first IDLE edge, i.e. one cycle after done.
- dividend/divisor changing during RUN has no effect.
- Arithmetic: unsigned only; the result satisfies dividend = quotient*divisor + remainder whenever ovf=0.

Optional Feature:
- Macro: DIV_EARLY_OUT_EN.
- Defined:
  - If ovf_int at acceptance, IDLE goes directly to DONE, skipping RUN.
  - done is asserted 1 edge after acceptance with the overflow result values.
  - busy stays 0 throughout.
- Not defined:
  - Overflow operations still run all WIDTH iterations.
  - done arrives at the normal WIDTH+1 latency.
  - Outputs are forced to the overflow values in DONE.
- Non-overflow operations are identical in both builds.

Test Plan:
- Reset during RUN: assert rst_n=0 two cycles into a divide -> immediately busy=0, done=0, quotient=0, remainder=0, ovf=0. After release, the next start completes normally.
- Basic divide: start with dividend=8'h8F (143), divisor=4'hC (12) -> done at 5th edge after acceptance, quotient=4'hB, remainder=4'hB, ovf=0. Results held until next start.
- Full-range result: dividend=8'hE1 (225), divisor=4'hF -> quotient=4'hF, remainder=4'h0, ovf=0. Also dividend=8'h00, divisor=4'h7 -> quotient=0, remainder=0, ovf=0.
- Overflow and divide-by-zero: dividend=8'h64, divisor=4'h0 -> ovf=1, quotient=4'hF, remainder=0. Also dividend=8'hF0, divisor=4'hF -> ovf=1.
  - Without DIV_EARLY_OUT_EN: done at edge 5.
  - With DIV_EARLY_OUT_EN: done at edge 1 and busy never high.
- Handshake: pulse start again while busy with different operands -> ignored, first result unchanged. Hold start high continuously -> back-to-back operations, each done separated by exactly one IDLE cycle.
- Exhaustive check for WIDTH=4: all dividends 0..255 with divisors 0..15, compared against a reference model of q = dividend/divisor, r = dividend%divisor, ovf = (q > 15 or divisor == 0).

Source files
------------

// File: rtl/seq_div_if.sv
// Start/busy/done handshake and operand/result bundle for the sequential divider.
interface seq_div_if #(
  parameter int WIDTH = 4
) ();
  logic               start;
  logic [2*WIDTH-1:0] dividend;
  logic [WIDTH-1:0]   divisor;
  logic               busy;
  logic               done;
  logic [WIDTH-1:0]   quotient;
  logic [WIDTH-1:0]   remainder;
  logic               ovf;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, ovf
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, ovf
  );
endinterface

// File: rtl/seq_div.sv
// Sequential restoring divider: 2*WIDTH-bit dividend / WIDTH-bit divisor, one quotient bit per clock.
// Optional DIV_EARLY_OUT_EN: overflowing divides skip the iteration phase and finish one edge after acceptance.
module seq_div #(
  parameter int WIDTH = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  seq_div_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] divisor_q;
  logic [WIDTH:0]   p_q;
  logic [WIDTH-1:0] s_q;
  logic [CW-1:0]    cnt_q;
  logic             ovf_int_q;
  logic [WIDTH-1:0] quotient_q;
  logic [WIDTH-1:0] remainder_q;
  logic             ovf_q;

  logic             accept;
  logic             ovf_acc;
  logic             last_iter;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             qbit;
  logic [WIDTH:0]   p_nx;
  logic [WIDTH-1:0] s_nx;

  // A quotient wider than WIDTH bits exists exactly when the upper dividend half reaches the divisor.
  assign ovf_acc   = (bus.dividend[2*WIDTH-1:WIDTH] >= bus.divisor);
  assign accept    = (state_q == IDLE) && bus.start;
  assign last_iter = (cnt_q == CW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
`ifdef DIV_EARLY_OUT_EN
          state_d = ovf_acc ? DONE : RUN;
`else
          state_d = RUN;
`endif
        end
      end
      RUN:     if (last_iter) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state_q == RUN);
    bus.done = (state_q == DONE);
  end

  always_comb begin
    shifted = {p_q[WIDTH-1:0], s_q[WIDTH-1]};
    trial   = shifted - {1'b0, divisor_q};
    qbit    = ~trial[WIDTH];
    p_nx    = qbit ? trial : shifted;
    s_nx    = {s_q[WIDTH-2:0], qbit};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      divisor_q   <= '0;
      p_q         <= '0;
      s_q         <= '0;
      cnt_q       <= '0;
      ovf_int_q   <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      ovf_q       <= 1'b0;
    end else begin
      if (accept) begin
        divisor_q <= bus.divisor;
        p_q       <= {1'b0, bus.dividend[2*WIDTH-1:WIDTH]};
        s_q       <= bus.dividend[WIDTH-1:0];
        cnt_q     <= CW'(WIDTH);
        ovf_int_q <= ovf_acc;
`ifdef DIV_EARLY_OUT_EN
        if (ovf_acc) begin
          quotient_q  <= '1;
          remainder_q <= '0;
          ovf_q       <= 1'b1;
        end
`endif
      end else if (state_q == RUN) begin
        p_q   <= p_nx;
        s_q   <= s_nx;
        cnt_q <= cnt_q - CW'(1);
        if (last_iter) begin
          if (ovf_int_q) begin
            quotient_q  <= '1;
            remainder_q <= '0;
            ovf_q       <= 1'b1;
          end else begin
            quotient_q  <= s_nx;
            remainder_q <= p_nx[WIDTH-1:0];
            ovf_q       <= 1'b0;
          end
        end
      end
    end
  end

  assign bus.quotient  = quotient_q;
  assign bus.remainder = remainder_q;
  assign bus.ovf       = ovf_q;
endmodule
